// File: rtl/counter_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// counter_arbiter_pkg
// Shared definitions for the counter arbiter slice: FSM state encoding,
// default time-slice length, and a small one-hot helper.
// No ports (package).
// -----------------------------------------------------------------------------
package counter_arbiter_pkg;

  // Default maximum number of RUN cycles a requester keeps the counter.
  localparam int unsigned DEFAULT_SLICE = 4;

  // Number of requesters sharing the counter.
  localparam int unsigned NUM_REQ = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_REL  = 2'd3
  } state_t;

  // Requester index -> one-hot grant vector.
  function automatic logic [NUM_REQ-1:0] onehot4(input logic [1:0] idx);
    onehot4 = 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/counter_arbiter_rr_pick4.sv
// -----------------------------------------------------------------------------
// rr_pick4
// Combinational round-robin picker for four requesters. The search starts
// at the requester after i_last_owner and wraps, so the previous owner has
// the lowest priority.
// Ports:
//   i_req        [3:0]  request vector, bit i = requester i
//   i_last_owner [1:0]  index of the most recently released owner
//   o_valid             at least one request is present
//   o_winner     [1:0]  index of the chosen requester (only meaningful when
//                       o_valid is high)
// -----------------------------------------------------------------------------
module rr_pick4 (
  input  logic [3:0] i_req,
  input  logic [1:0] i_last_owner,
  output logic       o_valid,
  output logic [1:0] o_winner
);

  logic [1:0] w_idx;

  // Scan from lowest priority (offset 4, i.e. last_owner itself) up to the
  // highest (offset 1); a later hit overwrites an earlier one, so the nearest
  // requester after last_owner ends up as the winner.
  always_comb begin
    o_valid  = |i_req;
    o_winner = i_last_owner;
    w_idx    = '0;
    for (int i = 4; i >= 1; i--) begin
      w_idx = i_last_owner + 2'(i);
      if (i_req[w_idx]) begin
        o_winner = w_idx;
      end
    end
  end

endmodule

// File: rtl/counter_arbiter.sv
// -----------------------------------------------------------------------------
// counter_arbiter
// Grants one of four requesters exclusive use of a shared loadable counter
// for a bounded time slice. Each grant is LOAD (parallel-load the owner's
// start value), up to SLICE cycles of RUN (count), then REL (one-cycle done
// pulse). Outputs are decoded from registered state only.
//
// Handshake: a requester raises req[i] and holds it for as long as it wants
// the counter. gnt[i] rises the cycle after req[i] is sampled in IDLE and
// stays high through LOAD and RUN. The grant ends when req[i] is sampled low
// in RUN or the slice expires; the arbiter then spends one REL cycle with
// done high and gnt low before it looks at requests again. Requests are not
// queued: anything sampled outside IDLE is ignored.
//
// Ports:
//   clk              clock, rising edge
//   rst              synchronous reset, active low
//   req        [3:0] per-requester request
//   start_data [15:0] per-requester counter start value, requester i on
//                    bits [4i+3:4i]
//   gnt        [3:0] one-hot grant, zero when there is no owner
//   cnt_enb          counter enable
//   cnt_modo         counter mode: 1 = parallel load, 0 = count
//   cnt_data   [3:0] counter parallel-load value
//   busy             high in LOAD and RUN
//   done             one-cycle pulse in REL
//   dbg_state        current FSM state, for observation only
// -----------------------------------------------------------------------------
module counter_arbiter
  import counter_arbiter_pkg::*;
#(
  parameter int unsigned SLICE = DEFAULT_SLICE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req,
  input  logic [15:0] start_data,
  output logic [3:0]  gnt,
  output logic        cnt_enb,
  output logic        cnt_modo,
  output logic [3:0]  cnt_data,
  output logic        busy,
  output logic        done,
  output state_t      dbg_state
);

  localparam logic [3:0] TIMER_LAST = 4'(SLICE - 1);

  state_t     r_state;
  logic [1:0] r_owner;
  logic [1:0] r_last_owner;
  logic [3:0] r_timer;

  state_t     w_state_nxt;
  logic [1:0] w_owner_nxt;
  logic [1:0] w_last_owner_nxt;
  logic [3:0] w_timer_nxt;

  logic       w_pick_valid;
  logic [1:0] w_pick_winner;
  logic       w_run_exit;

  rr_pick4 u_pick (
    .i_req        (req),
    .i_last_owner (r_last_owner),
    .o_valid      (w_pick_valid),
    .o_winner     (w_pick_winner)
  );

  // Slice expiry or owner withdrawal, whichever comes first.
  assign w_run_exit = (r_timer == TIMER_LAST) || !req[r_owner];

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_owner      <= 2'd0;
      r_last_owner <= 2'd3;
      r_timer      <= 4'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_owner      <= w_owner_nxt;
      r_last_owner <= w_last_owner_nxt;
      r_timer      <= w_timer_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_owner_nxt      = r_owner;
    w_last_owner_nxt = r_last_owner;
    w_timer_nxt      = r_timer;
    gnt              = '0;
    cnt_enb          = 1'b0;
    cnt_modo         = 1'b0;
    cnt_data         = '0;
    busy             = 1'b0;
    done             = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_pick_valid) begin
          w_state_nxt = ST_LOAD;
          w_owner_nxt = w_pick_winner;
        end
      end
      ST_LOAD: begin
        gnt         = onehot4(r_owner);
        cnt_enb     = 1'b1;
        cnt_modo    = 1'b1;
        cnt_data    = start_data[{r_owner, 2'b00} +: 4];
        busy        = 1'b1;
        // LOAD never aborts; the timer is cleared so RUN starts at zero.
        w_timer_nxt = 4'd0;
        w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        gnt         = onehot4(r_owner);
        cnt_enb     = 1'b1;
        busy        = 1'b1;
        w_timer_nxt = r_timer + 4'd1;
        if (w_run_exit) begin
          w_state_nxt = ST_REL;
        end
      end
      ST_REL: begin
        done             = 1'b1;
        w_last_owner_nxt = r_owner;
        w_state_nxt      = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign dbg_state = r_state;

endmodule

// File: tb/tb_counter_arbiter.sv
module tb_counter_arbiter;
  import counter_arbiter_pkg::*;

  localparam int SLICE = 4;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [15:0] start_data;
  logic [3:0]  gnt;
  logic        cnt_enb;
  logic        cnt_modo;
  logic [3:0]  cnt_data;
  logic        busy;
  logic        done;
  state_t      dbg_state;

  counter_arbiter #(.SLICE(SLICE)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .start_data (start_data),
    .gnt        (gnt),
    .cnt_enb    (cnt_enb),
    .cnt_modo   (cnt_modo),
    .cnt_data   (cnt_data),
    .busy       (busy),
    .done       (done),
    .dbg_state  (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // clock / reset
  // ---------------------------------------------------------------------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------------------------------------------------------------------
  // bookkeeping
  // ---------------------------------------------------------------------------
  int checks   = 0;
  int failures = 0;

  // Expected grant record: {gnt one-hot, load value, RUN length, counter end}
  logic [15:0] exp_q[$];

  logic [1:0] m_last;           // reference model: last released owner
  logic [3:0] tb_cnt = 4'd0;    // the shared counter the arbiter drives

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Round-robin reference: first requester after 'last', wrapping.
  function automatic logic [1:0] model_pick(input logic [3:0] pat, input logic [1:0] last);
    for (int i = 1; i <= 4; i++) begin
      int idx;
      idx = (int'(last) + i) % 4;
      if (pat[idx]) return 2'(idx);
    end
    return last;
  endfunction

  // req held high for 'hold' sampling edges starting at the IDLE edge:
  // the LOAD edge ignores it, so RUN sees (hold-1) high edges, at least 1
  // RUN cycle, at most SLICE.
  function automatic int model_len(input int hold);
    int l;
    l = (hold - 1 < 1) ? 1 : hold - 1;
    return (l > SLICE) ? SLICE : l;
  endfunction

  task automatic push_exp(input logic [1:0] own, input logic [15:0] data, input int len);
    int         o;
    logic [3:0] d;
    o = int'(own);
    d = data[o*4 +: 4];
    exp_q.push_back({4'(1 << o), d, 4'(len), 4'(int'(d) + len)});
  endtask

  // ---------------------------------------------------------------------------
  // external counter model
  // ---------------------------------------------------------------------------
  always @(posedge clk) begin
    if (cnt_enb) tb_cnt <= cnt_modo ? cnt_data : tb_cnt + 4'd1;
  end

  // ---------------------------------------------------------------------------
  // monitor / scoreboard
  // ---------------------------------------------------------------------------
  logic [3:0]  cap_gnt  = '0;
  logic [3:0]  cap_data = '0;
  int          run_cnt  = 0;
  logic        prev_run = 1'b0;
  logic [15:0] e;

  always @(negedge clk) begin
    if (!rst) begin
      run_cnt  = 0;
      prev_run = 1'b0;
    end else begin
      chk("gnt_onehot0", 16'($onehot0(gnt)), 16'd1);
      chk("enb_needs_gnt", 16'(!cnt_enb || (gnt != 4'd0)), 16'd1);
      chk("done_after_run", 16'(!done || prev_run), 16'd1);
      if (cnt_enb && cnt_modo) begin
        cap_gnt  = gnt;
        cap_data = cnt_data;
        run_cnt  = 0;
      end else if (cnt_enb) begin
        run_cnt++;
        chk("run_gnt_held", 16'(gnt), 16'(cap_gnt));
      end
      if (done) begin
        chk("done_gnt_zero", 16'(gnt), 16'h0);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done: got done=1 expected no grant end at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          chk("txn_gnt", 16'(cap_gnt), 16'(e[15:12]));
          chk("txn_load_data", 16'(cap_data), 16'(e[11:8]));
          chk("txn_run_len", 16'(run_cnt), 16'(e[7:4]));
          chk("txn_counter_end", 16'(tb_cnt), 16'(e[3:0]));
        end
      end
      prev_run = cnt_enb && !cnt_modo;
    end
  end

  // ---------------------------------------------------------------------------
  // driver tasks
  // ---------------------------------------------------------------------------
  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while ((busy || done) && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("idle_reached", 16'(busy || done), 16'd0);
  endtask

  task automatic do_txn(input logic [3:0] pat, input int hold, input logic [15:0] data);
    logic [1:0] own;
    wait_idle();
    start_data = data;
    req        = pat;
    own        = model_pick(pat, m_last);
    push_exp(own, data, model_len(hold));
    m_last = own;
    repeat (hold) @(posedge clk);
    #1 req = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_gnt"},      16'(gnt),       16'h0);
    chk({tag, "_cnt_enb"},  16'(cnt_enb),   16'h0);
    chk({tag, "_cnt_modo"}, 16'(cnt_modo),  16'h0);
    chk({tag, "_cnt_data"}, 16'(cnt_data),  16'h0);
    chk({tag, "_busy"},     16'(busy),      16'h0);
    chk({tag, "_done"},     16'(done),      16'h0);
    chk({tag, "_state"},    16'(dbg_state), 16'(ST_IDLE));
  endtask

  // ---------------------------------------------------------------------------
  // stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [1:0] own;
    int         n;

    rst        = 1'b0;
    req        = '0;
    start_data = '0;
    m_last     = 2'd3;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk);
    #1 rst = 1'b1;

    // All four requesting continuously: five back-to-back full slices.
    wait_idle();
    start_data = 16'hC3A7;
    req        = 4'hF;
    for (int g = 0; g < 5; g++) begin
      own = model_pick(4'hF, m_last);
      push_exp(own, start_data, SLICE);
      m_last = own;
    end
    repeat (4 * (SLICE + 3) + SLICE + 2) @(posedge clk);
    #1 req = '0;

    // Single requester 1, start value 5, held beyond the slice.
    do_txn(4'b0010, SLICE + 2, 16'h0050);
    // Early release: requester 0 drops during its second RUN cycle.
    do_txn(4'b0001, 3, 16'h000E);
    // One-cycle pulse: dropped during LOAD, single RUN cycle.
    do_txn(4'b0100, 1, 16'h0B00);

    // Reset during the third RUN cycle: no done, back to reset state.
    wait_idle();
    start_data = 16'h0009;
    req        = 4'b0001;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b0;
    req = '0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("midrun_reset");
    m_last = 2'd3;
    do_txn(4'b1001, 2, 16'h7004);
    do_txn(4'b1000, 2, 16'h7004);

    // Randomized grants.
    for (int t = 0; t < 40; t++) begin
      do_txn(4'($urandom_range(1, 15)), $urandom_range(1, SLICE + 2), 16'($urandom));
    end

    // Drain the scoreboard.
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk("queue_drained", 16'(exp_q.size()), 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/counter_arbiter.md
COUNTER_ARBITER -- requirements
Module: counter_arbiter

Interface
REQ-001 Parameter SLICE, default 4, SHALL set the maximum RUN cycles per grant (legal 1..15).
REQ-002 clk  input  1  SHALL be the clock; all state updates on its rising edge.
REQ-003 rst  input  1  SHALL be the reset, synchronous, active-low.
REQ-004 req  input  4  SHALL carry the per-requester access request, bit i = requester i.
REQ-005 start_data  input  16  SHALL carry the per-requester counter start value; requester i on bits [4i+3:4i].
REQ-006 gnt  output  4  SHALL be the one-hot grant (all-zero when no owner).
REQ-007 cnt_enb  output  1  SHALL drive the shared counter enable.
REQ-008 cnt_modo  output  1  SHALL drive the counter mode (1 = parallel load, 0 = count).
REQ-009 cnt_data  output  4  SHALL drive the counter parallel-load value.
REQ-010 busy  output  1  SHALL be high in LOAD and RUN.
REQ-011 done  output  1  SHALL pulse high for exactly one cycle at the end of each grant.

Function
REQ-012 The FSM SHALL have states IDLE, LOAD, RUN, REL; all outputs SHALL be decoded from registered state (Moore).
REQ-013 IDLE: gnt=0, cnt_enb=0; if any req bit is sampled high, the next state SHALL be LOAD with owner = winner of round-robin pick.
REQ-014 Round-robin: search SHALL start at (last_owner+1) mod 4 and wrap; last_owner resets to 3, so requester 0 has first priority.
REQ-015 LOAD (exactly 1 cycle): gnt=one-hot(owner), cnt_enb=1, cnt_modo=1, cnt_data=start_data slice of owner; next SHALL be RUN.
REQ-016 RUN: gnt held, cnt_enb=1, cnt_modo=0, cnt_data=0; 4-bit slice timer SHALL clear on entry and increment each RUN cycle.
REQ-017 RUN SHALL exit to REL when timer = SLICE-1 or req[owner] is sampled low, whichever first; max RUN length = SLICE cycles.
REQ-018 REL (exactly 1 cycle): gnt=0, cnt_enb=0, done=1, last_owner<=owner; next SHALL be IDLE.
REQ-019 Request latency: req high at edge k -> gnt visible after edge k; IDLE-to-IDLE minimum grant = 3 cycles (LOAD, RUN, REL).
REQ-020 req[owner] dropping during LOAD SHALL NOT abort the load; RUN then exits after its first cycle.
REQ-021 Requests from non-owners during LOAD/RUN/REL SHALL be ignored until IDLE; no pending queueing.
REQ-022 gnt SHALL never have more than one bit set; cnt_enb SHALL never be high while gnt is zero.
REQ-023 SLICE outside 1..15 is illegal; behaviour undefined.

Reset
REQ-024 With rst=0 at a rising edge: state=IDLE, last_owner=3, timer=0, gnt=0, cnt_enb=0, cnt_modo=0, cnt_data=0, busy=0, done=0.
REQ-025 Reset mid-grant (any state) SHALL abort immediately with no done pulse.

Structure
REQ-026 State encodings (IDLE=0, LOAD=1, RUN=2, REL=3) and default SLICE SHALL live in shared package counter_arbiter_pkg.
REQ-027 Round-robin selection SHALL be a combinational sub-module rr_pick4 (inputs req, last_owner; outputs valid, winner index).

Verification
REQ-028 Single requester: req=0010, start_data[7:4]=5, SLICE=4 held -> LOAD gnt=0010 cnt_data=5 modo=1, 4 RUN cycles, REL done=1, counter ends at 5+4 (wrapping per counter).
REQ-029 All request: req=1111 held from reset -> grants in order 0001,0010,0100,1000,0001, each LOAD+4 RUN+REL+IDLE.
REQ-030 Early release: req=0001, drop req[0] on 2nd RUN cycle -> REL next cycle, done=1, RUN length 2.
REQ-031 Drop during LOAD: req=0100 pulsed one cycle -> LOAD once, RUN 1 cycle, REL, IDLE.
REQ-032 Reset mid-RUN: rst=0 on 3rd RUN cycle -> next cycle all outputs 0, state IDLE, no done; next req=1000 -> 1000 wins after req=1001 pick gives 0001.
REQ-033 Assertions throughout: gnt one-hot-or-zero, cnt_enb implies gnt nonzero, done only after RUN.
